fx2_fifo_out_reader: RTL and testbench

- Stream-OUT counterpart of the FX2 slave-FIFO stream-IN writer. Drains host-to-device data from FX2 EP2 over the synchronous slave-FIFO bus (FD, SLOE, SLRD, FIFOADR).
- Presents each byte downstream on a one-entry valid/ready register.
- Maintains a byte counter and, optionally, an incrementing-pattern checker for bring-up against the host test application.

---
 rtl/fx2_pkg.sv | 36 +++
 rtl/fx2_fifo_out_reader_pattern_checker.sv | 31 +++
 rtl/fx2_fifo_out_reader.sv | 92 +++++++++
 tb/tb_fx2_fifo_out_reader.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/fx2_pkg.sv
// Shared FX2 slave-FIFO constants: endpoint addresses, one-hot FSM encodings for both directions,
// and the host test-pattern terminal byte.
package fx2_pkg;

   localparam logic [1:0] FIFO_EP2 = 2'b00;
   localparam logic [1:0] FIFO_EP4 = 2'b01;
   localparam logic [1:0] FIFO_EP6 = 2'b10;
   localparam logic [1:0] FIFO_EP8 = 2'b11;

   // Host test application sends packets counting 1..PATTERN_LAST, then restarts at 1.
   localparam logic [7:0] PATTERN_LAST  = 8'hAA;
   localparam logic [7:0] PATTERN_FIRST = 8'd1;

   // Stream-OUT (host to device) reader states.
   typedef enum logic [4:0] {
      RD_IDLE        = 5'b00001,
      RD_SELECT_FIFO = 5'b00010,
      RD_OE_SETUP    = 5'b00100,
      RD_CHECK_EMPTY = 5'b01000,
      RD_READ        = 5'b10000
   } rd_state_t;

   // Stream-IN (device to host) writer states.
   typedef enum logic [4:0] {
      WR_IDLE        = 5'b00001,
      WR_SELECT_FIFO = 5'b00010,
      WR_CHECK_FULL  = 5'b00100,
      WR_WRITE       = 5'b01000,
      WR_PKTEND      = 5'b10000
   } wr_state_t;

   function automatic logic [7:0] pattern_next(input logic [7:0] d);
      return (d == PATTERN_LAST) ? PATTERN_FIRST : d + 8'd1;
   endfunction

endpackage

// File: rtl/fx2_fifo_out_reader_pattern_checker.sv
// Tracks the expected incrementing host pattern and counts captured bytes that break it.
// Latency: err_count updates on the capture edge; resynchronises to the received byte after a miss.
module fx2_pattern_checker
   import fx2_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             capture,
   input  logic [7:0]       data,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   logic [7:0] expected;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         expected  <= PATTERN_FIRST;
         err_count <= '0;
      end else if (capture) begin
         if ((data != expected) && (err_count != CNT_MAX))
            err_count <= err_count + CNT_ONE;
         expected <= pattern_next(data);
      end
   end

endmodule

// File: rtl/fx2_fifo_out_reader.sv
// FX2 slave-FIFO stream-OUT reader: drains an endpoint into a one-entry valid/ready register.
// One byte per 2 cycles peak; holds off SLRD while the output register is full and unconsumed.
// Pattern checker is built only when FX2_PATTERN_CHECK_EN is defined; otherwise err_count is 0.
module fx2_fifo_out_reader
   import fx2_pkg::*;
#(
   parameter logic [1:0] FIFO_ADDR = FIFO_EP2,
   parameter int         CNT_W     = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flaga,
   input  logic [7:0]       fdata,
   output logic [1:0]       faddr,
   output logic             sloe,
   output logic             slrd,
   output logic [7:0]       m_data,
   output logic             m_valid,
   input  logic             m_ready,
   output logic [CNT_W-1:0] byte_count,
   output logic [CNT_W-1:0] err_count
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   rd_state_t state, state_nxt;
   logic      read_ok;
   logic      capture;

   assign faddr = FIFO_ADDR;

   // Only strobe when the endpoint has data and the output slot is free or freeing this cycle.
   assign read_ok = flaga && (!m_valid || m_ready);

   always_comb begin
      state_nxt = RD_IDLE;
      case (state)
         RD_IDLE:        state_nxt = RD_SELECT_FIFO;
         RD_SELECT_FIFO: state_nxt = RD_OE_SETUP;
         RD_OE_SETUP:    state_nxt = RD_CHECK_EMPTY;
         RD_CHECK_EMPTY: state_nxt = read_ok ? RD_READ : RD_CHECK_EMPTY;
         RD_READ:        state_nxt = RD_CHECK_EMPTY;
         default:        state_nxt = RD_IDLE;
      endcase
   end

   // Strobes come straight from flops so the FX2 never sees a combinational glitch.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= RD_IDLE;
         sloe  <= 1'b1;
         slrd  <= 1'b1;
      end else begin
         state <= state_nxt;
         sloe  <= (state_nxt == RD_IDLE);
         slrd  <= (state_nxt != RD_READ);
      end
   end

   assign capture = !slrd;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_data     <= 8'd0;
         m_valid    <= 1'b0;
         byte_count <= '0;
      end else begin
         if (capture) begin
            m_data     <= fdata;
            m_valid    <= 1'b1;
            byte_count <= byte_count + CNT_ONE;
         end else if (m_ready) begin
            m_valid <= 1'b0;
         end
      end
   end

`ifdef FX2_PATTERN_CHECK_EN
   fx2_pattern_checker #(
      .CNT_W(CNT_W)
   ) u_pattern_checker (
      .clk       (clk),
      .reset     (reset),
      .capture   (capture),
      .data      (fdata),
      .err_count (err_count)
   );
`else
   assign err_count = '0;
`endif

endmodule

// File: tb/tb_fx2_fifo_out_reader.sv
// Directed bench for fx2_fifo_out_reader with a behavioural FX2 endpoint and a draining consumer.
module tb_fx2_fifo_out_reader;

   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             reset = 1'b0;
   logic             flaga = 1'b0;
   logic [7:0]       fdata = 8'd0;
   logic [1:0]       faddr;
   logic             sloe;
   logic             slrd;
   logic [7:0]       m_data;
   logic             m_valid;
   logic             m_ready = 1'b0;
   logic [CNT_W-1:0] byte_count;
   logic [CNT_W-1:0] err_count;

   always #5 clk = ~clk;

   fx2_fifo_out_reader #(
      .FIFO_ADDR (2'b00),
      .CNT_W     (CNT_W)
   ) dut (
      .clk        (clk),
      .reset      (reset),
      .flaga      (flaga),
      .fdata      (fdata),
      .faddr      (faddr),
      .sloe       (sloe),
      .slrd       (slrd),
      .m_data     (m_data),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .byte_count (byte_count),
      .err_count  (err_count)
   );

   logic [7:0] mem [512];
   int         ptr = 0;
   int         avail = 0;
   logic [7:0] rx [$];
   int         pulses = 0;
   int         dbl_low = 0;
   int         cyc = 0;
   logic       prev_low = 1'b0;
   int         pulse_cyc [1024];
   int         n_chk = 0;
   int         n_pass = 0;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, act, exp);
   endtask

   task automatic wait_rx(input int n, input int budget, input string tag);
      int i = 0;
      while (rx.size() < n && i < budget) begin
         @(negedge clk);
         i++;
      end
      chk(tag, 32'(rx.size() >= n), 32'd1);
   endtask

   // Consumer monitor and strobe-shape tracking.
   always @(negedge clk) begin
      cyc++;
      if (reset && m_valid && m_ready) rx.push_back(m_data);
      if (!slrd) begin
         if (prev_low) dbl_low++;
         if (pulses < 1024) pulse_cyc[pulses] = cyc;
         pulses++;
      end
      prev_low = !slrd;
   end

   // FX2 endpoint model: a strobe low at the edge pops one byte.
   initial begin
      logic rd_now;
      forever begin
         @(negedge clk);
         rd_now = !slrd;
         @(posedge clk);
         #1;
         if (rd_now) ptr++;
         fdata = mem[ptr[8:0]];
         flaga = (ptr < avail);
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int bad;
      int i;
      int n0;
      int exp_err;
      for (int k = 0; k < 170; k++) mem[k] = 8'(k + 1);
      mem[170] = 8'd1; mem[171] = 8'd2; mem[172] = 8'd5; mem[173] = 8'd6;
      for (int k = 174; k < 512; k++) mem[k] = 8'(k);
      fdata = mem[0];

      // Reset state
      reset = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_sloe", 32'(sloe), 32'd1);
      chk("rst_slrd", 32'(slrd), 32'd1);
      chk("rst_m_valid", 32'(m_valid), 32'd0);
      chk("rst_m_data", 32'(m_data), 32'd0);
      chk("rst_byte_count", 32'(byte_count), 32'd0);
      chk("rst_err_count", 32'(err_count), 32'd0);
      chk("faddr", 32'(faddr), 32'd0);

      // Release with endpoint empty: one IDLE cycle, then parked waiting on flaga
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("idle_sloe", 32'(sloe), 32'd1);
      @(posedge clk);
      #1;
      chk("sloe_low", 32'(sloe), 32'd0);
      repeat (6) @(posedge clk);
      #1;
      chk("park_sloe", 32'(sloe), 32'd0);
      chk("park_slrd", 32'(slrd), 32'd1);
      chk("park_m_valid", 32'(m_valid), 32'd0);
      chk("park_pulses", 32'(pulses), 32'd0);

      // Full-rate packet 1..0xAA
      m_ready = 1'b1;
      avail = 170;
      wait_rx(170, 800, "stream_done");
      repeat (5) @(negedge clk);
      chk("stream_pulses", 32'(pulses), 32'd170);
      chk("stream_dbl_low", 32'(dbl_low), 32'd0);
      chk("stream_span", 32'(pulse_cyc[169] - pulse_cyc[0]), 32'd338);
      chk("stream_byte_count", 32'(byte_count), 32'd170);
      chk("stream_err_count", 32'(err_count), 32'd0);
      chk("stream_rx_size", 32'(rx.size()), 32'd170);
      bad = 0;
      for (int k = 0; k < 170 && k < rx.size(); k++) if (rx[k] != 8'(k + 1)) bad++;
      chk("stream_rx_order", 32'(bad), 32'd0);

      // Backpressure on the first byte of the next packet
      m_ready = 1'b0;
      avail = 174;
      i = 0;
      while (!m_valid && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk("bp_valid_seen", 32'(m_valid), 32'd1);
      repeat (10) @(negedge clk);
      chk("bp_m_data", 32'(m_data), 32'h01);
      chk("bp_m_valid", 32'(m_valid), 32'd1);
      chk("bp_pulses", 32'(pulses), 32'd171);
      chk("bp_slrd", 32'(slrd), 32'd1);
      @(posedge clk);
      #1;
      m_ready = 1'b1;
      wait_rx(174, 100, "bp_drain");
      repeat (4) @(negedge clk);
      chk("bp_rx0", 32'(rx[170]), 32'h01);
      chk("bp_rx1", 32'(rx[171]), 32'h02);
      chk("bp_rx2", 32'(rx[172]), 32'h05);
      chk("bp_rx3", 32'(rx[173]), 32'h06);
      chk("bp_byte_count", 32'(byte_count), 32'd174);
`ifdef FX2_PATTERN_CHECK_EN
      exp_err = 1;
`else
      exp_err = 0;
`endif
      chk("pattern_err_count", 32'(err_count), 32'(exp_err));
      chk("bp_dbl_low", 32'(dbl_low), 32'd0);

      // Reset asserted while the strobe is low
      avail = 400;
      i = 0;
      while (slrd && i < 50) begin
         @(negedge clk);
         i++;
      end
      chk("abort_strobe_seen", 32'(slrd), 32'd0);
      #2;
      reset = 1'b0;
      #1;
      chk("abort_slrd", 32'(slrd), 32'd1);
      chk("abort_sloe", 32'(sloe), 32'd1);
      chk("abort_m_valid", 32'(m_valid), 32'd0);
      chk("abort_byte_count", 32'(byte_count), 32'd0);
      chk("abort_err_count", 32'(err_count), 32'd0);
      @(posedge clk);
      #2;
      avail = ptr + 3;
      @(negedge clk);
      reset = 1'b1;
      n0 = rx.size();
      #1;
      chk("restart_idle_sloe", 32'(sloe), 32'd1);
      wait_rx(n0 + 3, 100, "restart_drain");
      repeat (10) @(negedge clk);
      chk("restart_byte_count", 32'(byte_count), 32'd3);
      chk("restart_rx_count", 32'(rx.size() - n0), 32'd3);
      chk("restart_m_valid", 32'(m_valid), 32'd0);
      chk("restart_dbl_low", 32'(dbl_low), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
